// File: rtl/cfu_arbiter.sv
// Round-robin arbiter sharing one CFU among NUM_PORTS requesters; an in-order
// tracking FIFO of granted port indices steers each CFU response home.
module cfu_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int ID_W            = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             p_req_valid,
   output logic [NUM_PORTS-1:0]             p_req_ready,
   input  logic [NUM_PORTS-1:0][ID_W-1:0]   p_req_id,
   input  logic [NUM_PORTS-1:0][31:0]       p_req_insn,
   input  logic [NUM_PORTS-1:0][31:0]       p_req_data0,
   input  logic [NUM_PORTS-1:0][31:0]       p_req_data1,
   input  logic [NUM_PORTS-1:0]             p_req_cfu_csr,
   output logic [NUM_PORTS-1:0]             p_resp_valid,
   input  logic [NUM_PORTS-1:0]             p_resp_ready,
   output logic [ID_W-1:0]                  p_resp_id,
   output logic [31:0]                      p_resp_data,
   output logic                             p_resp_status,
   output logic                             cfu_req_valid,
   input  logic                             cfu_req_ready,
   output logic [ID_W-1:0]                  cfu_req_id,
   output logic [31:0]                      cfu_req_insn,
   output logic [31:0]                      cfu_req_data0,
   output logic [31:0]                      cfu_req_data1,
   output logic                             cfu_req_cfu_csr,
   input  logic                             cfu_resp_valid,
   output logic                             cfu_resp_ready,
   input  logic [ID_W-1:0]                  cfu_resp_id,
   input  logic [31:0]                      cfu_resp_data,
   input  logic                             cfu_resp_status
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [PW-1:0]                       r_ptr;
   logic                                r_lock;
   logic [PW-1:0]                       r_lock_idx;
   logic [MAX_OUTSTANDING-1:0][PW-1:0]  r_fifo;
   logic [AW-1:0]                       r_wr;
   logic [AW-1:0]                       r_rd;
   logic [CW-1:0]                       r_count;

   logic [PW-1:0] w_sel_idx;
   logic [PW-1:0] w_grant_idx;
   logic [PW-1:0] w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
   assign w_empty = (r_count == '0);
   assign w_head  = r_fifo[r_rd];

   // First valid port at or after r_ptr, wrapping.
   always_comb begin
      int  j;
      logic found;
      w_sel_idx = r_ptr;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         if (!found && p_req_valid[j]) begin
            found     = 1'b1;
            w_sel_idx = j[PW-1:0];
         end
      end
   end

   // A stalled grant is frozen so the CFU sees a stable payload.
   assign w_grant_idx = r_lock ? r_lock_idx : w_sel_idx;

   assign cfu_req_valid   = (|p_req_valid) && !w_full;
   assign cfu_req_id      = p_req_id[w_grant_idx];
   assign cfu_req_insn    = p_req_insn[w_grant_idx];
   assign cfu_req_data0   = p_req_data0[w_grant_idx];
   assign cfu_req_data1   = p_req_data1[w_grant_idx];
   assign cfu_req_cfu_csr = p_req_cfu_csr[w_grant_idx];

   always_comb begin
      p_req_ready = '0;
      if (cfu_req_valid && cfu_req_ready) p_req_ready[w_grant_idx] = 1'b1;
   end

   assign w_push = cfu_req_valid && cfu_req_ready;

   always_comb begin
      p_resp_valid = '0;
      if (cfu_resp_valid && !w_empty) p_resp_valid[w_head] = 1'b1;
   end

   assign cfu_resp_ready = !w_empty && p_resp_ready[w_head];
   assign w_pop          = cfu_resp_valid && cfu_resp_ready;
   assign p_resp_id      = cfu_resp_id;
   assign p_resp_data    = cfu_resp_data;
   assign p_resp_status  = cfu_resp_status;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_push) begin
         r_ptr      <= (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + PW'(1);
         r_lock     <= 1'b0;
      end else if (cfu_req_valid && !r_lock) begin
         r_lock     <= 1'b1;
         r_lock_idx <= w_sel_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr] <= w_grant_idx;
            r_wr         <= (r_wr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr + AW'(1);
         end
         if (w_pop)
            r_rd <= (r_rd == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_cfu_arbiter.sv
// Directed bench for cfu_arbiter: the bench plays both requesters and the CFU.
module tb_cfu_arbiter;
   localparam int NP = 2;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NP-1:0]        p_req_valid;
   logic [NP-1:0]        p_req_ready;
   logic [NP-1:0][IW-1:0] p_req_id;
   logic [NP-1:0][31:0]  p_req_insn;
   logic [NP-1:0][31:0]  p_req_data0;
   logic [NP-1:0][31:0]  p_req_data1;
   logic [NP-1:0]        p_req_cfu_csr;
   logic [NP-1:0]        p_resp_valid;
   logic [NP-1:0]        p_resp_ready;
   logic [IW-1:0]        p_resp_id;
   logic [31:0]          p_resp_data;
   logic                 p_resp_status;
   logic                 cfu_req_valid;
   logic                 cfu_req_ready;
   logic [IW-1:0]        cfu_req_id;
   logic [31:0]          cfu_req_insn;
   logic [31:0]          cfu_req_data0;
   logic [31:0]          cfu_req_data1;
   logic                 cfu_req_cfu_csr;
   logic                 cfu_resp_valid;
   logic                 cfu_resp_ready;
   logic [IW-1:0]        cfu_resp_id;
   logic [31:0]          cfu_resp_data;
   logic                 cfu_resp_status;

   int n_chk = 0;
   int n_err = 0;

   cfu_arbiter #(.NUM_PORTS(NP), .ID_W(IW), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst(rst),
      .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_id(p_req_id),
      .p_req_insn(p_req_insn), .p_req_data0(p_req_data0), .p_req_data1(p_req_data1),
      .p_req_cfu_csr(p_req_cfu_csr),
      .p_resp_valid(p_resp_valid), .p_resp_ready(p_resp_ready), .p_resp_id(p_resp_id),
      .p_resp_data(p_resp_data), .p_resp_status(p_resp_status),
      .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready), .cfu_req_id(cfu_req_id),
      .cfu_req_insn(cfu_req_insn), .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
      .cfu_req_cfu_csr(cfu_req_cfu_csr),
      .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready), .cfu_resp_id(cfu_resp_id),
      .cfu_resp_data(cfu_resp_data), .cfu_resp_status(cfu_resp_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      p_req_valid = '0; p_req_id = '0; p_req_insn = '0; p_req_data0 = '0;
      p_req_data1 = '0; p_req_cfu_csr = '0; p_resp_ready = '0;
      cfu_req_ready = 1'b0; cfu_resp_valid = 1'b0; cfu_resp_id = '0;
      cfu_resp_data = '0; cfu_resp_status = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_req_valid", cfu_req_valid, 1'b0);
      chk("rst_resp_valid", p_resp_valid, 2'b00);
      chk("rst_resp_ready", cfu_resp_ready, 1'b0);
      // Stray CFU response while empty is never routed.
      cfu_resp_valid = 1'b1; p_resp_ready = 2'b11;
      #1;
      chk("empty_resp_valid", p_resp_valid, 2'b00);
      chk("empty_resp_ready", cfu_resp_ready, 1'b0);
      cfu_resp_valid = 1'b0;
      step();

      // Single port transaction.
      p_req_valid = 2'b01; p_req_id[0] = 4'h3; p_req_data0[0] = 32'd5;
      p_req_data1[0] = 32'd7; p_req_insn[0] = 32'h0000_000B; p_req_cfu_csr[0] = 1'b1;
      cfu_req_ready = 1'b1;
      #1;
      chk("single_req_valid", cfu_req_valid, 1'b1);
      chk("single_req_id", cfu_req_id, 4'h3);
      chk("single_req_d0", cfu_req_data0, 32'd5);
      chk("single_req_d1", cfu_req_data1, 32'd7);
      chk("single_req_insn", cfu_req_insn, 32'h0000_000B);
      chk("single_req_csr", cfu_req_cfu_csr, 1'b1);
      chk("single_p_ready", p_req_ready, 2'b01);
      step();
      p_req_valid = 2'b00; p_req_cfu_csr = '0;
      cfu_resp_valid = 1'b1; cfu_resp_id = 4'h3; cfu_resp_data = 32'd12; cfu_resp_status = 1'b1;
      #1;
      chk("single_resp_valid", p_resp_valid, 2'b01);
      chk("single_resp_id", p_resp_id, 4'h3);
      chk("single_resp_data", p_resp_data, 32'd12);
      chk("single_resp_status", p_resp_status, 1'b1);
      chk("single_resp_ready", cfu_resp_ready, 1'b1);
      step();
      #1;
      chk("single_drained", cfu_resp_ready, 1'b0);
      cfu_resp_valid = 1'b0; cfu_resp_status = 1'b0;

      // Round-robin until full, then full behaviour with a same-cycle pop.
      do_reset();
      p_req_valid = 2'b11; p_req_id[0] = 4'hA; p_req_id[1] = 4'hB;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("rr_grant", p_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_id", cfu_req_id, (c % 2 == 0) ? 4'hA : 4'hB);
         step();
      end
      cfu_resp_valid = 1'b1;
      #1;
      chk("full_req_valid", cfu_req_valid, 1'b0);
      chk("full_p_ready", p_req_ready, 2'b00);
      chk("full_pop_route", p_resp_valid, 2'b01);
      step();
      cfu_resp_valid = 1'b0;
      #1;
      chk("after_pop_valid", cfu_req_valid, 1'b1);
      chk("after_pop_grant", p_req_ready, 2'b01);
      step();
      p_req_valid = 2'b00;
      // FIFO now holds ports 1,0,1,0.
      cfu_resp_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("rr_route", p_resp_valid, (c % 2 == 0) ? 2'b10 : 2'b01);
         step();
      end
      #1;
      chk("rr_drained", cfu_resp_ready, 1'b0);
      cfu_resp_valid = 1'b0;

      // Response backpressure; ptr is 1 here.
      p_req_valid = 2'b10;
      step();
      p_req_valid = 2'b00;
      cfu_resp_valid = 1'b1; p_resp_ready = 2'b00;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("bp_valid", p_resp_valid, 2'b10);
         chk("bp_ready", cfu_resp_ready, 1'b0);
         step();
      end
      p_resp_ready = 2'b10;
      #1;
      chk("bp_accept", cfu_resp_ready, 1'b1);
      step();
      #1;
      chk("bp_drained", cfu_resp_ready, 1'b0);
      cfu_resp_valid = 1'b0; p_resp_ready = 2'b11;

      // Stall lock; ptr is 0 here.
      cfu_req_ready = 1'b0;
      p_req_valid = 2'b10; p_req_id[1] = 4'h5; p_req_data0[1] = 32'h111;
      p_req_id[0] = 4'h6; p_req_data0[0] = 32'h222;
      #1;
      chk("stall_id0", cfu_req_id, 4'h5);
      chk("stall_rdy0", p_req_ready, 2'b00);
      step();
      p_req_valid = 2'b11;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_id", cfu_req_id, 4'h5);
         chk("stall_d0", cfu_req_data0, 32'h111);
         step();
      end
      cfu_req_ready = 1'b1;
      #1;
      chk("stall_release", p_req_ready, 2'b10);
      step();
      p_req_valid = 2'b01;
      #1;
      chk("stall_next", p_req_ready, 2'b01);
      chk("stall_next_id", cfu_req_id, 4'h6);
      step();
      p_req_valid = 2'b00;

      // Reset with 2 outstanding; ptr was 1 before reset.
      do_reset();
      cfu_resp_valid = 1'b1;
      p_req_valid = 2'b11;
      #1;
      chk("rst2_resp_valid", p_resp_valid, 2'b00);
      chk("rst2_resp_ready", cfu_resp_ready, 1'b0);
      chk("rst2_ptr", p_req_ready, 2'b01);
      step();
      p_req_valid = 2'b00; cfu_resp_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/cfu_arbiter.md
# cfu_arbiter

Shares one custom functional unit (CFU) between NUM_PORTS independent requesters, such as multiple issue ports or cores. It sits between the requesters' CFU request/response channels and the single CFU instance. Requests are granted round-robin. An in-order tracking FIFO routes each CFU response back to the port that issued it.

## Interface
Parameters:
- NUM_PORTS, 2: number of requester ports, ≥2.
- ID_W, 4: width of req_id/resp_id.
- MAX_OUTSTANDING, 4: tracking FIFO depth, power of two, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- p_req_valid  in  [NUM_PORTS]  per-port request valid.
- p_req_ready  out  [NUM_PORTS]  per-port request accepted.
- p_req_id  in  [NUM_PORTS][ID_W]  request id.
- p_req_insn  in  [NUM_PORTS][32]  instruction word.
- p_req_data0, p_req_data1  in  [NUM_PORTS][32]  operands.
- p_req_cfu_csr  in  [NUM_PORTS]  CSR-type request flag.
- p_resp_valid  out  [NUM_PORTS]  per-port response valid.
- p_resp_ready  in  [NUM_PORTS]  per-port response accept.
- p_resp_id  out  [ID_W]  response id, broadcast to all ports.
- p_resp_data  out  32  response data, broadcast.
- p_resp_status  out  1  response status, broadcast.
- cfu_req_valid/ready, cfu_req_id, cfu_req_insn, cfu_req_data0/1, cfu_req_cfu_csr: CFU request side, mirrored widths, arbiter drives valid and payload.
- cfu_resp_valid/ready, cfu_resp_id, cfu_resp_data, cfu_resp_status: CFU response side, arbiter drives ready.

## Operation
- Priority pointer ptr in [0, NUM_PORTS-1]. Reset value is 0.
- Selection: the first port with p_req_valid, searching from ptr upward and wrapping modulo NUM_PORTS.
- Grant lock: when cfu_req_valid=1 and cfu_req_ready=0, the current winner is registered. The grant stays fixed until handshake, so cfu_req payload is stable while stalled.
- cfu_req_valid = any p_req_valid & ~fifo_full. Payload is muxed from the granted port.
- p_req_ready[i] = grant[i] & cfu_req_ready & ~fifo_full.
- On request handshake:
  - push the granted index into the tracking FIFO.
  - ptr ← (grant+1) mod NUM_PORTS.
  - clear the lock.
- Response routing: head = FIFO head index.
  - p_resp_valid[head] = cfu_resp_valid & ~fifo_empty.
  - All other p_resp_valid are 0.
  - cfu_resp_ready = ~fifo_empty & p_resp_ready[head].
  - Response id, data and status pass through unchanged.
- On response handshake, pop the FIFO.
- Full: no issue while full, even if a pop occurs the same cycle.
- Empty: cfu_resp_ready=0. A cfu_resp_valid while empty is a protocol error, held off and never routed.
- Simultaneous push and pop with count unchanged is legal. FIFO pointers wrap modulo MAX_OUTSTANDING.
- Occupancy counter is 0..MAX_OUTSTANDING. fifo_full = (count==MAX_OUTSTANDING).

## Timing
- Reset values:
  - ptr=0, lock clear, count=0, FIFO pointers 0.
  - p_resp_valid all 0, cfu_resp_ready=0.
  - cfu_req_valid=0 while no port is valid.
- Request path is zero-latency combinational. There is no added cycle between p_req_valid and cfu_req_valid.
- Response path is zero-latency combinational. FIFO push and pop take effect at the next edge.
- Back-to-back issue every cycle is possible while CFU is ready and FIFO is not full.
- Reset mid-operation discards tracked entries. The CFU is reset concurrently, so in-flight responses never return.
- Requesters hold valid and payload until ready; they must not withdraw.

## Test plan
- Single port: port 0 sends id=3, data0=5, data1=7 → one cfu_req; CFU returns data 12, id 3 → p_resp_valid[0]=1 only, pop, count back to 0.
- Round-robin: ports 0 and 1 valid continuously, CFU always ready → grants 0,1,0,1; responses route to 0,1,0,1 in order.
- Stall lock: port 1 granted with cfu_req_ready=0 for 3 cycles while port 0 raises valid → payload stays port 1's; port 0 is granted next.
- Full: MAX_OUTSTANDING=4, CFU accepts 4 and withholds responses → cfu_req_valid=0 on the 5th. A pop and a new request in the same cycle → no issue that cycle, issue the next.
- Response backpressure: head port drives p_resp_ready=0 for 2 cycles → cfu_resp_ready=0, FIFO unchanged; accepted on the 3rd cycle.
- Reset with 2 outstanding → count=0, ptr=0, all p_resp_valid=0 on the next cycle.
